// File: rtl/eth_pkt_rd_ctrl_if.sv
// Handshake bundle between the packet read controller, its source FIFO and the UDP sender.
interface eth_pkt_rd_ctrl_if #(
  parameter int unsigned LVL_WIDTH = 11
);
  logic [31:0]          fifo_rd_data;
  logic                 fifo_rd_empty;
  logic [LVL_WIDTH-1:0] fifo_rd_water_level;
  logic                 fifo_rd_en;
  logic                 tx_start_en;
  logic [15:0]          tx_byte_num;
  logic                 tx_req;
  logic [31:0]          tx_data;
  logic                 tx_done;
  logic [15:0]          pkt_cnt;
  logic                 err;

  modport master (
    input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, tx_req, tx_done,
    output fifo_rd_en, tx_start_en, tx_byte_num, tx_data, pkt_cnt, err
  );

  modport slave (
    output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, tx_req, tx_done,
    input  fifo_rd_en, tx_start_en, tx_byte_num, tx_data, pkt_cnt, err
  );
endinterface

// File: rtl/eth_pkt_rd_ctrl.sv
// Reads full packets from a FIFO and paces them out to a UDP sender on its tx_req strobes.
// Optional macro ETH_PKT_RD_FLUSH_EN: flush a partial packet after TIMEOUT_CYCLES idle cycles.
module eth_pkt_rd_ctrl #(
  parameter int unsigned PKT_WORDS      = 256,
  parameter int unsigned LVL_WIDTH      = 11,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic              clk,
  input logic              rst_n,
  eth_pkt_rd_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;

  localparam logic [LVL_WIDTH-1:0] PKT_LVL = LVL_WIDTH'(PKT_WORDS);

  state_t     state;
  logic [9:0] remaining;
  logic       rd_ok;

`ifdef ETH_PKT_RD_FLUSH_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Read strobe follows tx_req in the same cycle so data lands one cycle later.
  assign rd_ok = (state == SEND) && bus.tx_req && (remaining != '0) && !bus.fifo_rd_empty;
  assign bus.fifo_rd_en = rd_ok;
  assign bus.tx_data    = bus.fifo_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      remaining       <= '0;
      bus.tx_start_en <= 1'b0;
      bus.tx_byte_num <= '0;
      bus.pkt_cnt     <= '0;
      bus.err         <= 1'b0;
`ifdef ETH_PKT_RD_FLUSH_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      bus.tx_start_en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.fifo_rd_water_level >= PKT_LVL) begin
            state           <= START;
            remaining       <= 10'(PKT_WORDS);
            bus.tx_byte_num <= 16'(PKT_WORDS * 4);
            bus.tx_start_en <= 1'b1;
            bus.pkt_cnt     <= bus.pkt_cnt + 16'd1;
`ifdef ETH_PKT_RD_FLUSH_EN
            tmo_cnt         <= '0;
          end else if (bus.fifo_rd_water_level != '0) begin
            if (tmo_cnt == TMO_LAST) begin
              state           <= START;
              remaining       <= 10'(bus.fifo_rd_water_level);
              bus.tx_byte_num <= 16'(bus.fifo_rd_water_level) << 2;
              bus.tx_start_en <= 1'b1;
              bus.pkt_cnt     <= bus.pkt_cnt + 16'd1;
              tmo_cnt         <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end else begin
            tmo_cnt <= '0;
`endif
          end
        end
        START: state <= SEND;
        SEND: begin
          // An early tx_done abandons the rest of the packet in the FIFO.
          if (bus.tx_done) begin
            state   <= IDLE;
            bus.err <= 1'b1;
          end else begin
            if (rd_ok) begin
              remaining <= remaining - 10'd1;
              if (remaining == 10'd1) state <= WAIT_DONE;
            end
            if (bus.tx_req && bus.fifo_rd_empty) bus.err <= 1'b1;
          end
        end
        WAIT_DONE: if (bus.tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
